// File: rtl/keysw_pkg.sv
// Shared bus addresses and CTRL register bit positions for the KEY/SW responder.
package keysw_pkg;

  localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
  localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
  localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 2;
  localparam int IE_BIT      = 8;

  function automatic logic [31:0] ctrl_word(input logic ready, input logic overrun,
                                            input logic ie);
    logic [31:0] w;
    w              = '0;
    w[READY_BIT]   = ready;
    w[OVERRUN_BIT] = overrun;
    w[IE_BIT]      = ie;
    return w;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a group of async inputs; accept latency DEBOUNCE_CYCLES+2..+4 edges.
// No backpressure: o_evt is a one-cycle pulse on the edge where o_stable changes.
module input_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable,
  output logic             o_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_sync_q;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt;
  logic             w_hold;
  logic             w_accept;

  // Count only while the synchronized value is steady and differs from the accepted one.
  assign w_hold   = (r_sync == r_sync_q) && (r_sync != r_stable);
  assign w_accept = w_hold && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_sync_q <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_meta   <= i_raw;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      if (!w_hold || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_stable <= r_sync;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_evt    = w_accept;

endmodule

// File: rtl/keysw_responder.sv
// Memory-mapped KEY/SW responder with sticky Ready/Overrun; irq output only when KEYSW_IRQ_EN is defined.
// Reads are combinational from addr, writes and read-clears act on the next edge; no backpressure.
module keysw_responder
  import keysw_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter int               DEBOUNCE_CYCLES = 100000,
  parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(KDATA_ADDR),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(KCTRL_ADDR),
  parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(SDATA_ADDR),
  parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(SCTRL_ADDR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             rdEn,
  input  logic             wrEn,
  input  logic [DBITS-1:0] wrData,
  output logic [DBITS-1:0] rdData,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW
`ifdef KEYSW_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [3:0] w_key_stable;
  logic       w_key_evt;
  logic [9:0] w_sw_stable;
  logic       w_sw_evt;
  logic       w_kclr, w_sclr, w_kwr, w_swr;
  logic       w_kie, w_sie;
  logic       w_unused_wr;
  logic       r_kready, r_kovr, r_sready, r_sovr;

  input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (~KEY),
    .o_stable (w_key_stable),
    .o_evt    (w_key_evt)
  );

  input_debouncer #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (SW),
    .o_stable (w_sw_stable),
    .o_evt    (w_sw_evt)
  );

  assign w_kclr      = rdEn && (addr == ADDR_KDATA);
  assign w_sclr      = rdEn && (addr == ADDR_SDATA);
  assign w_kwr       = wrEn && (addr == ADDR_KCTRL);
  assign w_swr       = wrEn && (addr == ADDR_SCTRL);
  assign w_unused_wr = ^wrData;

  // A change event beats a coincident clearing read; Overrun set beats a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kready <= 1'b0;
      r_kovr   <= 1'b0;
      r_sready <= 1'b0;
      r_sovr   <= 1'b0;
    end else begin
      r_kready <= w_key_evt | (r_kready & ~w_kclr);
      r_sready <= w_sw_evt | (r_sready & ~w_sclr);
      r_kovr   <= (w_key_evt & r_kready & ~w_kclr) |
                  (r_kovr & ~(w_kwr & ~wrData[OVERRUN_BIT]));
      r_sovr   <= (w_sw_evt & r_sready & ~w_sclr) |
                  (r_sovr & ~(w_swr & ~wrData[OVERRUN_BIT]));
    end
  end

`ifdef KEYSW_IRQ_EN
  logic r_kie, r_sie, r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kie <= 1'b0;
      r_sie <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_kwr) r_kie <= wrData[IE_BIT];
      if (w_swr) r_sie <= wrData[IE_BIT];
      r_irq <= (r_kready & r_kie) | (r_sready & r_sie);
    end
  end

  assign w_kie = r_kie;
  assign w_sie = r_sie;
  assign irq   = r_irq;
`else
  assign w_kie = 1'b0;
  assign w_sie = 1'b0;
`endif

  always_comb begin
    rdData = '0;
    if (addr == ADDR_KDATA) begin
      rdData[3:0] = w_key_stable;
    end else if (addr == ADDR_SDATA) begin
      rdData[9:0] = w_sw_stable;
    end else if (addr == ADDR_KCTRL) begin
      rdData = DBITS'(ctrl_word(r_kready, r_kovr, w_kie));
    end else if (addr == ADDR_SCTRL) begin
      rdData = DBITS'(ctrl_word(r_sready, r_sovr, w_sie));
    end
  end

endmodule

// File: tb/tb_keysw_responder.sv
// Scoreboard bench for keysw_responder: randomized settled/glitch inputs and bus traffic vs. a register-level model.
module tb_keysw_responder;
  import keysw_pkg::*;

  localparam int DB     = 4;
  localparam int SETTLE = DB + 8;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] addr   = '0;
  logic [31:0] wrData = '0;
  logic [31:0] rdData;
  logic        rdEn   = 1'b0;
  logic        wrEn   = 1'b0;
  logic [3:0]  KEY    = 4'hF;
  logic [9:0]  SW     = '0;
`ifdef KEYSW_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 0;

  logic [31:0] exp_q[$];
  logic [31:0] adr_q[$];
  logic [31:0] mon_exp, mon_adr;

  // Reference model: accepted values and sticky status bits
  logic [3:0] m_key;
  logic [9:0] m_sw;
  logic       m_kr, m_ko, m_sr, m_so, m_kie, m_sie;

  keysw_responder #(.DBITS(32), .DEBOUNCE_CYCLES(DB)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .rdEn   (rdEn),
    .wrEn   (wrEn),
    .wrData (wrData),
    .rdData (rdData),
    .KEY    (KEY),
    .SW     (SW)
`ifdef KEYSW_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_exp(input logic r, input logic o, input logic ie);
    return 32'(r) | (32'(o) << 2) | (32'(ie) << 8);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a == KDATA_ADDR) return {28'b0, m_key};
    if (a == SDATA_ADDR) return {22'b0, m_sw};
    if (a == KCTRL_ADDR) return ctrl_exp(m_kr, m_ko, m_kie);
    if (a == SCTRL_ADDR) return ctrl_exp(m_sr, m_so, m_sie);
    return 32'h0;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return KDATA_ADDR;
      1:       return KCTRL_ADDR;
      2:       return SDATA_ADDR;
      3:       return SCTRL_ADDR;
      4:       return 32'hF000_0018;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_key = '0; m_sw = '0;
    m_kr = 0; m_ko = 0; m_sr = 0; m_so = 0; m_kie = 0; m_sie = 0;
  endtask

  task automatic key_event(input logic [3:0] v);
    if (v != m_key) begin
      m_ko  = m_ko | m_kr;
      m_kr  = 1'b1;
      m_key = v;
    end
  endtask

  task automatic sw_event(input logic [9:0] v);
    if (v != m_sw) begin
      m_so = m_so | m_sr;
      m_sr = 1'b1;
      m_sw = v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a);
    tick();
    addr = a;
    rdEn = 1'b1;
    exp_q.push_back(model_read(a));
    adr_q.push_back(a);
    if (a == KDATA_ADDR) m_kr = 1'b0;
    if (a == SDATA_ADDR) m_sr = 1'b0;
    tick();
    rdEn = 1'b0;
    addr = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    tick();
    addr   = a;
    wrData = d;
    wrEn   = 1'b1;
    if (a == KCTRL_ADDR) begin
      if (!d[2]) m_ko = 1'b0;
`ifdef KEYSW_IRQ_EN
      m_kie = d[8];
`endif
    end
    if (a == SCTRL_ADDR) begin
      if (!d[2]) m_so = 1'b0;
`ifdef KEYSW_IRQ_EN
      m_sie = d[8];
`endif
    end
    tick();
    wrEn = 1'b0;
    addr = '0;
  endtask

  task automatic set_key(input logic [3:0] act);
    tick();
    KEY = ~act;
    repeat (SETTLE) @(posedge clk);
    #1;
    key_event(act);
  endtask

  task automatic set_sw(input logic [9:0] v);
    tick();
    SW = v;
    repeat (SETTLE) @(posedge clk);
    #1;
    sw_event(v);
  endtask

  task automatic glitch_key(input logic [3:0] act, input int len);
    tick();
    KEY = ~act;
    repeat (len) @(posedge clk);
    #1;
    KEY = ~m_key;
    repeat (SETTLE) @(posedge clk);
    #1;
  endtask

  task automatic glitch_sw(input logic [9:0] v, input int len);
    tick();
    SW = v;
    repeat (len) @(posedge clk);
    #1;
    SW = m_sw;
    repeat (SETTLE) @(posedge clk);
    #1;
  endtask

  // Monitor: every load cycle presents rdData; compare against the queued expectation.
  always @(negedge clk) begin
    if (rdEn) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_read addr=%h actual=%h required=none", addr, rdData);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_adr = adr_q.pop_front();
        if (rdData !== mon_exp) begin
          failures++;
          $display("FAIL read_%h actual=%h required=%h", mon_adr, rdData, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    do_read(KDATA_ADDR);
    do_read(KCTRL_ADDR);
    do_read(SDATA_ADDR);
    do_read(SCTRL_ADDR);

    // Press KEY[0] and measure edges until Ready appears
    tick();
    KEY = 4'b1110;
    for (int n = 1; n <= DB + 10 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      addr = KCTRL_ADDR;
      #1;
      if (rdData[0]) lat = n;
    end
    addr = KDATA_ADDR;
    #1;
    check("press_kdata", rdData, 32'h1);
    checks++;
    if (lat < DB + 2 || lat > DB + 4) begin
      failures++;
      $display("FAIL press_latency actual=%0d required=%0d..%0d", lat, DB + 2, DB + 4);
      lat = DB + 3;
    end
    addr = '0;
    key_event(4'b0001);
    do_read(KDATA_ADDR);
    do_read(KCTRL_ADDR);

    glitch_key(4'b0011, DB - 1);
    do_read(KDATA_ADDR);
    do_read(KCTRL_ADDR);

    set_sw(10'h001);
    set_sw(10'h003);
    do_read(SCTRL_ADDR);
    do_write(SCTRL_ADDR, 32'h0);
    do_read(SCTRL_ADDR);
    do_read(SDATA_ADDR);
    do_read(SCTRL_ADDR);

    // KDATA load on the same edge as a new key event: Ready survives, no Overrun
    set_key(4'b0011);
    tick();
    KEY = ~4'b0111;
    repeat (lat - 1) @(posedge clk);
    #1;
    addr = KDATA_ADDR;
    rdEn = 1'b1;
    exp_q.push_back(model_read(KDATA_ADDR));
    adr_q.push_back(KDATA_ADDR);
    m_kr  = 1'b1;
    m_key = 4'b0111;
    tick();
    rdEn = 1'b0;
    addr = '0;
    do_read(KCTRL_ADDR);

    // Overrun clear on the same edge as an overrun-setting event: set wins
    tick();
    KEY = ~4'b1111;
    repeat (lat - 1) @(posedge clk);
    #1;
    addr   = KCTRL_ADDR;
    wrData = 32'h0;
    wrEn   = 1'b1;
    m_ko   = m_kr;
    m_kr   = 1'b1;
    m_key  = 4'b1111;
    m_kie  = 1'b0;
    tick();
    wrEn = 1'b0;
    addr = '0;
    do_read(KCTRL_ADDR);
    do_write(KCTRL_ADDR, 32'h4);
    do_read(KCTRL_ADDR);
    do_write(KCTRL_ADDR, 32'h0);
    do_read(KCTRL_ADDR);
    do_read(KDATA_ADDR);
    do_read(KCTRL_ADDR);

`ifdef KEYSW_IRQ_EN
    begin
      bit found;
      do_write(KCTRL_ADDR, 32'h100);
      set_key(4'b0000);
      do_read(KDATA_ADDR);
      tick();
      check("irq_idle", irq, 1'b0);
      KEY   = ~4'b1000;
      found = 1'b0;
      for (int n = 1; n <= DB + 10 && !found; n++) begin
        @(posedge clk);
        #1;
        addr = KCTRL_ADDR;
        #1;
        if (rdData[0]) begin
          found = 1'b1;
          check("irq_lags_ready", irq, 1'b0);
        end
      end
      check("irq_ready_seen", found, 1'b1);
      addr = '0;
      @(posedge clk);
      #1;
      check("irq_set", irq, 1'b1);
      key_event(4'b1000);
      do_read(KDATA_ADDR);
      check("irq_hold", irq, 1'b1);
      @(posedge clk);
      #1;
      check("irq_clear", irq, 1'b0);
    end
`endif

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0:       set_key(4'($urandom));
        1:       set_sw(10'($urandom));
        2:       glitch_key(4'($urandom), $urandom_range(1, DB - 1));
        3:       glitch_sw(10'($urandom), $urandom_range(1, DB - 1));
        6:       do_write(pick_addr(), $urandom);
        default: do_read(pick_addr());
      endcase
    end

    // Key held through reset is re-accepted after debounce
    tick();
    KEY   = ~4'b0101;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (SETTLE) @(posedge clk);
    #1;
    key_event(4'b0101);
    sw_event(SW);
    do_read(KCTRL_ADDR);
    do_read(KDATA_ADDR);
    do_read(SDATA_ADDR);
    do_read(SCTRL_ADDR);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
